// File: rtl/axis_bram_load_ctrl.sv
// AXI4-Stream to BRAM loader: writes cfg_len beats starting at cfg_base and
// shares the single BRAM port with a core read requester served only when idle.
module axis_bram_load_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              ACLK,
    input  logic              ARESETN,

    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W:0]   cfg_len,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,

    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,

    input  logic              core_rd_req,
    input  logic [ADDR_W-1:0] core_rd_addr,
    output logic              core_rd_gnt,

    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] ONE = 1;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   cnt_q;
    logic              done_q;
    logic              err_q;

    logic              handshake;
    logic              last_beat;

    assign s_axis_tready = (state == LOAD) || (state == DRAIN);
    assign handshake     = s_axis_tvalid & s_axis_tready;
    assign last_beat     = (cnt_q == (len_q - ONE));

    assign cfg_busy = (state != IDLE);
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state  <= IDLE;
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        err_q <= 1'b0;
                        if (cfg_len != '0) begin
                            base_q <= cfg_base;
                            len_q  <= cfg_len;
                            cnt_q  <= '0;
                            state  <= LOAD;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        cnt_q <= cnt_q + ONE;
                        // Final counted beat without tlast: discard the rest of the packet.
                        if (last_beat) begin
                            if (s_axis_tlast) begin
                                state  <= DONE;
                                done_q <= 1'b1;
                            end else begin
                                err_q <= 1'b1;
                                state <= DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            err_q  <= 1'b1;
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake && s_axis_tlast) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Loader owns the port outside IDLE; reads are also masked while reset is held.
    always_comb begin
        bram_en     = 1'b0;
        bram_we     = 1'b0;
        bram_addr   = '0;
        bram_din    = '0;
        core_rd_gnt = 1'b0;
        if ((state == LOAD) && handshake) begin
            bram_en   = 1'b1;
            bram_we   = 1'b1;
            bram_addr = base_q + cnt_q[ADDR_W-1:0];
            bram_din  = s_axis_tdata;
        end else if ((state == IDLE) && core_rd_req && ARESETN) begin
            core_rd_gnt = 1'b1;
            bram_en     = 1'b1;
            bram_addr   = core_rd_addr;
        end
    end

endmodule

// File: doc/axis_bram_load_ctrl.md
AXIS_BRAM_LOAD_CTRL -- requirements
Module: axis_bram_load_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: AXIS and BRAM data width.
REQ-002 SHALL have parameter ADDR_W, default 10: BRAM word-address width.
REQ-003 SHALL have port ACLK, input, 1: the only clock; all state changes on its rising edge.
REQ-004 SHALL have port ARESETN, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_start, input, 1: one-cycle load command.
REQ-006 SHALL have port cfg_base, input, ADDR_W: first BRAM word address, sampled with cfg_start.
REQ-007 SHALL have port cfg_len, input, ADDR_W+1: beats to write, sampled with cfg_start.
REQ-008 SHALL have port cfg_busy, output, 1: high while not in IDLE.
REQ-009 SHALL have port cfg_done, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port cfg_err, output, 1: sticky framing-error flag.
REQ-011 SHALL have ports s_axis_tdata (DATA_W), s_axis_tvalid (1) and s_axis_tlast (1) as inputs, and s_axis_tready (1) as output: AXI4-Stream slave.
REQ-012 SHALL have ports core_rd_req (1) and core_rd_addr (ADDR_W) as inputs, and core_rd_gnt (1) as output: core read requester.
REQ-013 SHALL have ports bram_en (1), bram_we (1), bram_addr (ADDR_W) and bram_din (DATA_W), all outputs: single shared BRAM port.

Function
REQ-014 SHALL implement states IDLE, LOAD, DRAIN and DONE.
REQ-015 SHALL, in IDLE, on cfg_start with cfg_len != 0: latch base and len, clear beat count and cfg_err, and enter LOAD next cycle.
REQ-016 SHALL, in IDLE, on cfg_start with cfg_len == 0: clear cfg_err, pulse cfg_done the next cycle and stay in IDLE.
REQ-017 SHALL ignore cfg_start in any state other than IDLE.
REQ-018 SHALL hold s_axis_tready = 1 in LOAD and DRAIN only, and 0 in IDLE and DONE.
REQ-019 SHALL define a handshake as s_axis_tvalid & s_axis_tready; no beat is written or counted without one.
REQ-020 SHALL, on a LOAD handshake, combinationally drive in the same cycle: bram_en = 1, bram_we = 1, bram_din = s_axis_tdata, bram_addr = (base + cnt) mod 2^ADDR_W; cnt increments after the edge.
REQ-021 SHALL, on a LOAD handshake with cnt == len-1 and tlast = 1, enter DONE.
REQ-022 SHALL, on a LOAD handshake with cnt == len-1 and tlast = 0, set cfg_err and enter DRAIN.
REQ-023 SHALL, on a LOAD handshake with cnt < len-1 and tlast = 1, write the beat, set cfg_err and enter DONE.
REQ-024 SHALL, in DRAIN, accept beats without writing BRAM (bram_en = 0) and enter DONE on the handshake carrying tlast = 1.
REQ-025 SHALL, in DONE, assert cfg_done for exactly one cycle and return to IDLE.
REQ-026 SHALL keep cfg_err set until the next accepted cfg_start or reset.
REQ-027 SHALL arbitrate the BRAM port with the loader always having priority: core_rd_gnt = core_rd_req only in IDLE, and 0 otherwise.
REQ-028 SHALL, on a core read grant, combinationally drive bram_en = 1, bram_we = 0, bram_addr = core_rd_addr; read data return is outside this block.
REQ-029 SHALL drive bram_en = 0 and bram_we = 0 in all other cycles.
REQ-030 SHALL, on a core read request that coincides with a cfg_start in IDLE, grant the read that cycle; the load begins the next cycle.

Reset
REQ-031 SHALL, while ARESETN = 0, immediately force: state IDLE, cnt 0, cfg_busy 0, cfg_done 0, cfg_err 0, s_axis_tready 0, bram_en 0, bram_we 0, core_rd_gnt 0.
REQ-032 SHALL, on reset asserted mid-LOAD or mid-DRAIN, abandon the transfer; no cfg_done pulse follows reset release.

Verification
REQ-033 SHALL cover nominal load: base 0x010, len 4, four beats with tlast on the 4th -> writes to 0x010..0x013 with matching data, one cfg_done pulse, cfg_err = 0.
REQ-034 SHALL cover address wrap: base 0x3FE, len 4 -> writes to 0x3FE, 0x3FF, 0x000, 0x001.
REQ-035 SHALL cover early tlast: len 4, tlast on the 2nd beat -> 2 writes, cfg_err = 1, cfg_done pulse, return to IDLE.
REQ-036 SHALL cover late tlast: len 2, tlast on the 4th beat -> 2 writes; beats 3 and 4 accepted with bram_en = 0; cfg_err = 1; cfg_done after beat 4.
REQ-037 SHALL cover arbitration: core_rd_req held through a load -> core_rd_gnt = 0 from LOAD through DONE; gnt = 1 with bram_we = 0 in IDLE; cfg_start during LOAD ignored.
REQ-038 SHALL cover edge cases: len = 0 -> cfg_done one cycle later with no writes; ARESETN pulsed low after 2 of 4 beats -> all outputs reset and no cfg_done.
